// File: rtl/ras.sv
// Return address stack: circular buffer of predicted return targets.
// Overflow overwrites the oldest entry; the pointer is restorable from checkpoints.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] pop_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty
);

    localparam int IW = RAS_INDEX_WIDTH;
    localparam int CW = RAS_INDEX_WIDTH + 1;
    localparam int TW = RAS_TARGET_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(RAS_ENTRIES);

    logic [TW-1:0] entry_q [RAS_ENTRIES];
    logic [TW-1:0] entry_d [RAS_ENTRIES];
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] count_q, count_d;

    logic [IW-1:0] top_idx;
    logic          empty;

    assign top_idx = index_q - IW'(1);
    assign empty   = (count_q == '0);

    always_comb begin
        entry_d = entry_q;
        index_d = index_q;
        count_d = count_q;
        if (restore_valid) begin
            index_d = restore_index;
            count_d = (restore_count > FULL) ? FULL : restore_count;
        end else if (push_valid && pop_valid && !empty) begin
            // Tail call: replace the top entry in place
            entry_d[top_idx] = push_target;
        end else if (push_valid) begin
            entry_d[index_q] = push_target;
            index_d = index_q + IW'(1);
            count_d = (count_q == FULL) ? FULL : count_q + CW'(1);
        end else if (pop_valid && !empty) begin
            index_d = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            index_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    assign pop_target = entry_q[top_idx];
    assign ras_index  = index_q;
    assign ras_count  = count_q;
    assign ras_empty  = empty;

endmodule

// File: tb/tb_ras.sv
// Directed bench for ras: LIFO order, wrap, underflow, replace,
// restore priority and asynchronous reset.
module tb_ras;

    logic        CLK;
    logic        nRST;
    logic        push_valid;
    logic [30:0] push_target;
    logic        pop_valid;
    logic        restore_valid;
    logic [2:0]  restore_index;
    logic [3:0]  restore_count;
    logic [30:0] pop_target;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        ras_empty;

    int checks;
    int failures;

    ras dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .push_valid   (push_valid),
        .push_target  (push_target),
        .pop_valid    (pop_valid),
        .restore_valid(restore_valid),
        .restore_index(restore_index),
        .restore_count(restore_count),
        .pop_target   (pop_target),
        .ras_index    (ras_index),
        .ras_count    (ras_count),
        .ras_empty    (ras_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic push(input logic [30:0] v);
        push_valid  = 1'b1;
        push_target = v;
        tick();
        push_valid  = 1'b0;
    endtask

    task automatic pop();
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        nRST          = 1'b0;
        push_valid    = 1'b0;
        push_target   = '0;
        pop_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
        #12;
        check("rst_target", 32'(pop_target), 32'h0);
        check("rst_index", 32'(ras_index), 32'd0);
        check("rst_count", 32'(ras_count), 32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        do_reset();

        // LIFO order
        push(31'h1000);
        push(31'h2000);
        push(31'h3000);
        check("lifo_top", 32'(pop_target), 32'h3000);
        check("lifo_count", 32'(ras_count), 32'd3);
        check("lifo_index", 32'(ras_index), 32'd3);
        check("lifo_pop0", 32'(pop_target), 32'h3000);
        pop();
        check("lifo_pop1", 32'(pop_target), 32'h2000);
        pop();
        check("lifo_pop2", 32'(pop_target), 32'h1000);
        pop();
        check("lifo_empty", 32'(ras_empty), 32'd1);
        check("lifo_index0", 32'(ras_index), 32'd0);

        // Overflow wrap
        do_reset();
        for (int i = 1; i <= 9; i++) push(31'(i));
        check("wrap_count", 32'(ras_count), 32'd8);
        check("wrap_index", 32'(ras_index), 32'd1);
        check("wrap_top", 32'(pop_target), 32'd9);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("wrap_pop%0d", k), 32'(pop_target), 32'(9 - k));
            pop();
        end
        check("wrap_count0", 32'(ras_count), 32'd0);
        check("wrap_index_end", 32'(ras_index), 32'd1);

        // Underflow
        do_reset();
        pop();
        check("uf_index", 32'(ras_index), 32'd0);
        check("uf_count", 32'(ras_count), 32'd0);
        check("uf_empty", 32'(ras_empty), 32'd1);
        check("uf_target", 32'(pop_target), 32'd0);
        // push+pop while empty acts as a push
        push_valid  = 1'b1;
        pop_valid   = 1'b1;
        push_target = 31'h55;
        tick();
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
        check("pp_empty_idx", 32'(ras_index), 32'd1);
        check("pp_empty_cnt", 32'(ras_count), 32'd1);
        check("pp_empty_top", 32'(pop_target), 32'h55);

        // Simultaneous push and pop replaces top
        do_reset();
        push(31'hA);
        push(31'hB);
        push_valid  = 1'b1;
        pop_valid   = 1'b1;
        push_target = 31'hC;
        tick();
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
        check("pp_top", 32'(pop_target), 32'hC);
        check("pp_count", 32'(ras_count), 32'd2);
        check("pp_index", 32'(ras_index), 32'd2);
        pop();
        check("pp_after_pop", 32'(pop_target), 32'hA);

        // Restore priority over push
        do_reset();
        push(31'h10);
        push(31'h20);
        push(31'h30);
        restore_valid = 1'b1;
        restore_index = 3'd1;
        restore_count = 4'd1;
        push_valid    = 1'b1;
        push_target   = 31'h40;
        tick();
        push_valid    = 1'b0;
        check("rs_index", 32'(ras_index), 32'd1);
        check("rs_count", 32'(ras_count), 32'd1);
        check("rs_top", 32'(pop_target), 32'h10);
        restore_index = 3'd4;
        restore_count = 4'd15;
        tick();
        restore_valid = 1'b0;
        check("rs_entry3", 32'(pop_target), 32'd0);
        check("rs_sat", 32'(ras_count), 32'd8);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 1; i <= 5; i++) push(31'(i * 16));
        check("ar_count5", 32'(ras_count), 32'd5);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("ar_target", 32'(pop_target), 32'd0);
        check("ar_index", 32'(ras_index), 32'd0);
        check("ar_count", 32'(ras_count), 32'd0);
        check("ar_empty", 32'(ras_empty), 32'd1);
        tick();
        nRST = 1'b1;
        push(31'h77);
        check("ar_post_top", 32'(pop_target), 32'h77);
        check("ar_post_cnt", 32'(ras_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
